// File: rtl/seq_det_pkg.sv
// Shared constants for the sequence-detector family.
// The serializer and the detectors use the same word width and idle fill bit.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned SEQ_DET_WIDTH    = 8;
    localparam logic        SEQ_DET_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_det_bit_serializer.sv
// Parallel-in/serial-out front end that feeds the serial In port of a detector.
// Words are accepted over valid/ready, and back-to-back words form a gap-free bit stream.
module seq_det_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH     = SEQ_DET_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = SEQ_DET_IDLE_BIT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [WIDTH-1:0]         Din,
    input  logic                     Din_valid,
    output logic                     Din_ready,
    output logic                     Sout,
    output logic                     Sout_valid,
    output logic                     Word_done,
    output logic [$clog2(WIDTH)-1:0] Bit_cnt
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    // The bit at the output end of a word: this is the next bit to drive on Sout.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last      = (cnt == LAST);
    assign Din_ready = !Rst && ((state == ST_IDLE) || ((state == ST_SHIFT) && last));
    assign accept    = Din_valid && Din_ready;
    assign Word_done = Sout_valid && last;
    assign Bit_cnt   = cnt;

    always_comb begin
        sr_shift = MSB_FIRST ? (sr << 1) : (sr >> 1);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            sr         <= '0;
            cnt        <= '0;
            Sout       <= IDLE_BIT;
            Sout_valid <= 1'b0;
        end else if (accept) begin
            // An accept in the last-bit cycle reloads the register with no fill gap.
            state      <= ST_SHIFT;
            sr         <= Din;
            cnt        <= '0;
            Sout       <= head(Din);
            Sout_valid <= 1'b1;
        end else if ((state == ST_SHIFT) && !last) begin
            sr         <= sr_shift;
            cnt        <= cnt + CW'(1);
            Sout       <= head(sr_shift);
        end else begin
            state      <= ST_IDLE;
            cnt        <= '0;
            Sout       <= IDLE_BIT;
            Sout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_det_bit_serializer.sv
// Scoreboard bench: a driver pushes the expected bit sequence of every accepted word,
// and a monitor pops and compares on every cycle for the MSB-first and LSB-first instances.
module tb_seq_det_bit_serializer;
    import seq_det_pkg::*;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [W-1:0] Din = '0;
    logic         Din_valid = 1'b0;

    logic         m_ready, m_sout, m_valid, m_done;
    logic [2:0]   m_cnt;
    logic         l_ready, l_sout, l_valid, l_done;
    logic [2:0]   l_cnt;

    typedef struct {
        logic        bm;
        logic        bl;
        int unsigned idx;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned det_cnt = 0;
    int unsigned det_m = 0;

    seq_det_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_valid(Din_valid), .Din_ready(m_ready),
        .Sout(m_sout), .Sout_valid(m_valid), .Word_done(m_done), .Bit_cnt(m_cnt)
    );

    seq_det_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_valid(Din_valid), .Din_ready(l_ready),
        .Sout(l_sout), .Sout_valid(l_valid), .Word_done(l_done), .Bit_cnt(l_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the queue holds every bit still owed, the front one being on Sout now.
    always @(negedge Clk) begin
        exp_t e;
        chk("m_ready", {31'd0, m_ready}, {31'd0, !Rst && (q.size() <= 1)});
        chk("l_ready", {31'd0, l_ready}, {31'd0, !Rst && (q.size() <= 1)});
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("m_valid", {31'd0, m_valid}, 32'd1);
            chk("l_valid", {31'd0, l_valid}, 32'd1);
            chk("m_sout", {31'd0, m_sout}, {31'd0, e.bm});
            chk("l_sout", {31'd0, l_sout}, {31'd0, e.bl});
            chk("m_bitcnt", {29'd0, m_cnt}, e.idx);
            chk("l_bitcnt", {29'd0, l_cnt}, e.idx);
            chk("m_done", {31'd0, m_done}, {31'd0, e.idx == W - 1});
            chk("l_done", {31'd0, l_done}, {31'd0, e.idx == W - 1});
        end else begin
            chk("m_idle_valid", {31'd0, m_valid}, 32'd0);
            chk("l_idle_valid", {31'd0, l_valid}, 32'd0);
            chk("m_idle_sout", {31'd0, m_sout}, {31'd0, SEQ_DET_IDLE_BIT});
            chk("l_idle_sout", {31'd0, l_sout}, {31'd0, SEQ_DET_IDLE_BIT});
            chk("m_idle_done", {31'd0, m_done}, 32'd0);
            chk("m_idle_bitcnt", {29'd0, m_cnt}, 32'd0);
        end
    end

    // Non-overlapping 1010 detector that looks at the MSB-first stream once per cycle.
    always @(negedge Clk) begin
        if (Rst) begin
            det_m = 0;
        end else if (m_sout == ((det_m % 2) == 0)) begin
            det_m = det_m + 1;
            if (det_m == 4) begin
                det_cnt = det_cnt + 1;
                det_m = 0;
            end
        end else begin
            det_m = m_sout ? 1 : 0;
        end
    end

    task automatic send(input logic [W-1:0] w);
        logic acc;
        acc = 1'b0;
        Din = w;
        Din_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge Clk);
            acc = m_ready;
            @(posedge Clk);
            if (acc) begin
                for (int unsigned b = 0; b < W; b++)
                    q.push_back('{bm: w[W-1-b], bl: w[b], idx: b});
            end
        end
        chk("accept_timeout", {31'd0, acc}, 32'd1);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        Din_valid = 1'b0;
        Din = W'($urandom);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        int unsigned d0;
        int unsigned d1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        send(8'hA5);
        idle(12);

        send(8'hA5);
        send(8'h3C);
        idle(12);

        // 8'hFF is presented during every bit of 8'hA5 and must be loaded once.
        send(8'hA5);
        send(8'hFF);
        idle(12);

        send(8'h0A);
        idle(10);

        send(8'hA5);
        Din_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        Din_valid = 1'b1;
        Din = 8'hFF;
        @(posedge Clk);
        q.delete();
        #1;
        Rst = 1'b0;
        idle(4);
        send(8'hA5);
        idle(12);

        d0 = det_cnt;
        send(8'hAA);
        send(8'h0A);
        d1 = det_cnt;
        chk("det_aa", d1 - d0, 32'd2);
        idle(W + 4);
        chk("det_0a", det_cnt - d1, 32'd1);

        repeat (60) begin
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 10));
            send(W'($urandom));
        end
        idle(W + 4);
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
